// File: rtl/wb_victim_cache_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cache_defs
//   Shared definitions for the write-back victim cache controller:
//   default geometry, the controller state encoding and a state helper.
//
//   Optional feature macro used by the controller: VC_PERF_CNT_EN
// ----------------------------------------------------------------------------
package cache_defs;

   // Default number of victim lines (power of two, at least 2).
   localparam int VC_ENTRIES  = 4;
   // Default line-address width (byte address without line-offset bits).
   localparam int VC_TAG_BITS = 26;

   typedef enum logic [2:0] {
      VC_IDLE,
      VC_WRB,
      VC_INSERT,
      VC_FLUSH,
      VC_FLUSH_WRB,
      VC_DONE
   } type_vcache_states_e;

   // True in the states that drive a write-back request towards memory.
   function automatic logic is_wrb_state(input type_vcache_states_e st);
      return (st == VC_WRB) || (st == VC_FLUSH_WRB);
   endfunction

endpackage

// File: rtl/wb_victim_cache_ctrl_way_sel.sv
// ----------------------------------------------------------------------------
// vc_way_sel
//   Combinational way selection for the victim cache.
//   - Compares the probe address against every valid tag.
//   - Converts the match vector to a way index (lowest index wins if the
//     vector were ever not one-hot).
//   - Finds the lowest-index invalid entry for insert targeting.
//
// Ports
//   tags        in   N x TAG   stored line addresses
//   valid       in   N         entry valid bits
//   lookup_addr in   TAG       probed line address
//   hit         out  1         some valid entry matches lookup_addr
//   hit_way     out  log2(N)   matching way (0 on miss)
//   free_found  out  1         at least one entry is invalid
//   free_way    out  log2(N)   lowest-index invalid entry (0 if none)
// ----------------------------------------------------------------------------
module vc_way_sel #(
   parameter int  VC_ENTRIES  = cache_defs::VC_ENTRIES,
   parameter int  VC_TAG_BITS = cache_defs::VC_TAG_BITS,
   localparam int WAY_BITS    = $clog2(VC_ENTRIES)
) (
   input  logic [VC_ENTRIES-1:0][VC_TAG_BITS-1:0] tags,
   input  logic [VC_ENTRIES-1:0]                  valid,
   input  logic [VC_TAG_BITS-1:0]                 lookup_addr,
   output logic                                   hit,
   output logic [WAY_BITS-1:0]                    hit_way,
   output logic                                   free_found,
   output logic [WAY_BITS-1:0]                    free_way
);

   logic [VC_ENTRIES-1:0] match;

   genvar gi;
   generate
      for (gi = 0; gi < VC_ENTRIES; gi++) begin : g_cmp
         assign match[gi] = valid[gi] && (tags[gi] == lookup_addr);
      end
   endgenerate

   assign hit        = |match;
   assign free_found = ~&valid;

   // Walk from the top down so the lowest set index is the last one kept.
   always_comb begin
      hit_way  = '0;
      free_way = '0;
      for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_way = WAY_BITS'(i);
         end
         if (!valid[i]) begin
            free_way = WAY_BITS'(i);
         end
      end
   end

endmodule

// File: rtl/wb_victim_cache_ctrl.sv
// ----------------------------------------------------------------------------
// wb_victim_cache_ctrl
//   Controller for the write-back victim cache next to the L1 dcache.
//   Keeps tag/valid/dirty state of a small fully associative victim buffer,
//   answers lookups combinationally, chooses insert ways (first free entry,
//   otherwise FIFO order) and sequences write-back of dirty victims and
//   flushes. Line data is held in the separate vcache datapath, which is
//   steered by vc_wr_en_o / vc_wr_way_o / vc_rd_way_o.
//
//   Optional feature macro: VC_PERF_CNT_EN
//     defined   : 32-bit wrapping event counters (swap, insert ack, mem ack)
//     undefined : counter ports present but tied to 0, no counter flops
//
// Ports
//   clk              in   1        clock
//   rst_n            in   1        synchronous reset, active low
//   lookup_addr_i    in   TAG      line address probed by the dcache
//   lookup_hit_o     out  1        combinational hit
//   lookup_way_o     out  log2(N)  hit way (0 on miss)
//   swap_i           in   1        dcache takes the hit line; invalidate it
//   insert_req_i     in   1        insert request (level, held until ack/kill)
//   insert_addr_i    in   TAG      line address being inserted
//   insert_dirty_i   in   1        inserted line is dirty
//   insert_ack_o     out  1        entry written this cycle
//   vc_wr_en_o       out  1        datapath write strobe
//   vc_wr_way_o      out  log2(N)  datapath write way
//   vc_rd_way_o      out  log2(N)  datapath read way
//   vc2mem_req_o     out  1        write-back request
//   vc2mem_wr_o      out  1        write-back is a write
//   vc2mem_addr_o    out  TAG      write-back line address
//   mem2vc_ack_i     in   1        memory accepted the write-back
//   vc_flush_i       in   1        write back dirty entries, invalidate all
//   vc_flush_done_o  out  1        one-cycle pulse when the flush completes
//   vc_kill_i        in   1        abort the current sequence
//   vc_hit_cnt_o     out  32       swap counter
//   vc_ins_cnt_o     out  32       insert-ack counter
//   vc_wrb_cnt_o     out  32       memory-ack counter
// ----------------------------------------------------------------------------
module wb_victim_cache_ctrl #(
   parameter int  VC_ENTRIES  = cache_defs::VC_ENTRIES,
   parameter int  VC_TAG_BITS = cache_defs::VC_TAG_BITS,
   localparam int WAY_BITS    = $clog2(VC_ENTRIES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [VC_TAG_BITS-1:0] lookup_addr_i,
   output logic                   lookup_hit_o,
   output logic [WAY_BITS-1:0]    lookup_way_o,
   input  logic                   swap_i,
   input  logic                   insert_req_i,
   input  logic [VC_TAG_BITS-1:0] insert_addr_i,
   input  logic                   insert_dirty_i,
   output logic                   insert_ack_o,
   output logic                   vc_wr_en_o,
   output logic [WAY_BITS-1:0]    vc_wr_way_o,
   output logic [WAY_BITS-1:0]    vc_rd_way_o,
   output logic                   vc2mem_req_o,
   output logic                   vc2mem_wr_o,
   output logic [VC_TAG_BITS-1:0] vc2mem_addr_o,
   input  logic                   mem2vc_ack_i,
   input  logic                   vc_flush_i,
   output logic                   vc_flush_done_o,
   input  logic                   vc_kill_i,
   output logic [31:0]            vc_hit_cnt_o,
   output logic [31:0]            vc_ins_cnt_o,
   output logic [31:0]            vc_wrb_cnt_o
);

   import cache_defs::type_vcache_states_e;
   import cache_defs::VC_IDLE;
   import cache_defs::VC_WRB;
   import cache_defs::VC_INSERT;
   import cache_defs::VC_FLUSH;
   import cache_defs::VC_FLUSH_WRB;
   import cache_defs::VC_DONE;
   import cache_defs::is_wrb_state;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   type_vcache_states_e                   state_reg;
   logic [VC_ENTRIES-1:0][VC_TAG_BITS-1:0] tag_reg;
   logic [VC_ENTRIES-1:0]                 valid_reg;
   logic [VC_ENTRIES-1:0]                 dirty_reg;
   logic [WAY_BITS-1:0]                   fifo_ptr_reg;
   logic [WAY_BITS-1:0]                   scan_idx_reg;
   // Victim way chosen when an insert had to wait for a write-back.
   logic [WAY_BITS-1:0]                   wrb_way_reg;

   // ------------------------------------------------------------------
   // Way selection
   // ------------------------------------------------------------------
   logic                hit;
   logic [WAY_BITS-1:0] hit_way;
   logic                free_found;
   logic [WAY_BITS-1:0] free_way;

   vc_way_sel #(
      .VC_ENTRIES  (VC_ENTRIES),
      .VC_TAG_BITS (VC_TAG_BITS)
   ) u_way_sel (
      .tags        (tag_reg),
      .valid       (valid_reg),
      .lookup_addr (lookup_addr_i),
      .hit         (hit),
      .hit_way     (hit_way),
      .free_found  (free_found),
      .free_way    (free_way)
   );

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic                in_idle;
   logic                swap_hit;
   logic                swap_clear;
   logic [WAY_BITS-1:0] target_way;
   logic                target_wrb;
   logic                idle_insert;
   logic                insert_write;
   logic [WAY_BITS-1:0] write_way;
   logic                wrb_active;
   logic [WAY_BITS-1:0] rd_way;
   logic                scan_last;
   logic                scan_needs_wrb;

   assign in_idle  = (state_reg == VC_IDLE);
   assign swap_hit = swap_i & hit;

   // Swaps only take effect in IDLE: that is the only state in which the
   // datapath read port follows the lookup way, so only then can the dcache
   // actually consume the hit line.
   assign swap_clear = in_idle & swap_hit & ~vc_kill_i;

   // A swap in the same cycle as an insert hands the freed way straight to
   // the incoming line; otherwise first free entry, else FIFO victim.
   assign target_way = swap_hit   ? hit_way :
                       free_found ? free_way : fifo_ptr_reg;

   // A write-back is needed only when the FIFO victim is chosen and dirty
   // (all entries are valid whenever the FIFO victim is chosen).
   assign target_wrb = ~swap_hit & ~free_found & dirty_reg[fifo_ptr_reg];

   // Flush has priority over insert in IDLE; kill blocks everything.
   assign idle_insert  = in_idle & ~vc_kill_i & ~vc_flush_i & insert_req_i & ~target_wrb;
   assign insert_write = idle_insert | ((state_reg == VC_INSERT) & ~vc_kill_i);
   assign write_way    = (state_reg == VC_INSERT) ? wrb_way_reg : target_way;

   // Kill drops the memory request in the same cycle.
   assign wrb_active = is_wrb_state(state_reg) & ~vc_kill_i;

   assign rd_way = in_idle ? hit_way :
                   ((state_reg == VC_WRB) || (state_reg == VC_INSERT)) ? wrb_way_reg :
                   scan_idx_reg;

   assign scan_last      = (scan_idx_reg == WAY_BITS'(VC_ENTRIES - 1));
   assign scan_needs_wrb = valid_reg[scan_idx_reg] & dirty_reg[scan_idx_reg];

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign lookup_hit_o    = hit;
   assign lookup_way_o    = hit_way;
   assign insert_ack_o    = insert_write;
   assign vc_wr_en_o      = insert_write;
   assign vc_wr_way_o     = write_way;
   assign vc_rd_way_o     = rd_way;
   assign vc2mem_req_o    = wrb_active;
   assign vc2mem_wr_o     = wrb_active;
   assign vc2mem_addr_o   = wrb_active ? tag_reg[rd_way] : '0;
   assign vc_flush_done_o = (state_reg == VC_DONE) & ~vc_kill_i;

   // ------------------------------------------------------------------
   // Sequencer and entry state
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= VC_IDLE;
         tag_reg      <= '0;
         valid_reg    <= '0;
         dirty_reg    <= '0;
         fifo_ptr_reg <= '0;
         scan_idx_reg <= '0;
         wrb_way_reg  <= '0;
      end else begin
         // Clear first so a same-cycle insert into the swapped way wins.
         if (swap_clear) begin
            valid_reg[hit_way] <= 1'b0;
         end
         if (insert_write) begin
            tag_reg[write_way]   <= insert_addr_i;
            valid_reg[write_way] <= 1'b1;
            dirty_reg[write_way] <= insert_dirty_i;
         end

         if (vc_kill_i) begin
            state_reg    <= VC_IDLE;
            scan_idx_reg <= '0;
         end else begin
            case (state_reg)
               VC_IDLE: begin
                  if (vc_flush_i) begin
                     state_reg    <= VC_FLUSH;
                     scan_idx_reg <= '0;
                  end else if (insert_req_i) begin
                     if (target_wrb) begin
                        state_reg   <= VC_WRB;
                        wrb_way_reg <= fifo_ptr_reg;
                     end else if (!swap_hit && !free_found) begin
                        // Clean valid victim replaced in place.
                        fifo_ptr_reg <= fifo_ptr_reg + WAY_BITS'(1);
                     end
                  end
               end

               VC_WRB: begin
                  if (mem2vc_ack_i) begin
                     state_reg <= VC_INSERT;
                  end
               end

               VC_INSERT: begin
                  // The written way is always the FIFO victim here.
                  fifo_ptr_reg <= fifo_ptr_reg + WAY_BITS'(1);
                  state_reg    <= VC_IDLE;
               end

               VC_FLUSH: begin
                  if (scan_needs_wrb) begin
                     state_reg <= VC_FLUSH_WRB;
                  end else begin
                     valid_reg[scan_idx_reg] <= 1'b0;
                     dirty_reg[scan_idx_reg] <= 1'b0;
                     if (scan_last) begin
                        state_reg <= VC_DONE;
                     end else begin
                        scan_idx_reg <= scan_idx_reg + WAY_BITS'(1);
                     end
                  end
               end

               VC_FLUSH_WRB: begin
                  if (mem2vc_ack_i) begin
                     valid_reg[scan_idx_reg] <= 1'b0;
                     dirty_reg[scan_idx_reg] <= 1'b0;
                     if (scan_last) begin
                        state_reg <= VC_DONE;
                     end else begin
                        state_reg    <= VC_FLUSH;
                        scan_idx_reg <= scan_idx_reg + WAY_BITS'(1);
                     end
                  end
               end

               VC_DONE: begin
                  fifo_ptr_reg <= '0;
                  scan_idx_reg <= '0;
                  state_reg    <= VC_IDLE;
               end

               default: begin
                  state_reg <= VC_IDLE;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Optional event counters
   // ------------------------------------------------------------------
`ifdef VC_PERF_CNT_EN
   logic [31:0] hit_cnt_reg;
   logic [31:0] ins_cnt_reg;
   logic [31:0] wrb_cnt_reg;
   logic        mem_accept;

   assign mem_accept = wrb_active & mem2vc_ack_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hit_cnt_reg <= '0;
         ins_cnt_reg <= '0;
         wrb_cnt_reg <= '0;
      end else begin
         if (swap_clear) begin
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
         end
         if (insert_write) begin
            ins_cnt_reg <= ins_cnt_reg + 32'd1;
         end
         if (mem_accept) begin
            wrb_cnt_reg <= wrb_cnt_reg + 32'd1;
         end
      end
   end

   assign vc_hit_cnt_o = hit_cnt_reg;
   assign vc_ins_cnt_o = ins_cnt_reg;
   assign vc_wrb_cnt_o = wrb_cnt_reg;
`else
   assign vc_hit_cnt_o = '0;
   assign vc_ins_cnt_o = '0;
   assign vc_wrb_cnt_o = '0;
`endif

endmodule
